// File: rtl/wb_uart_arbiter.sv
// Two-requester round-robin arbiter in front of a single wb_uart register port.
// Each access issues a one-cycle strobe, waits the UART read latency, then acks the winner.
module wb_uart_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_dat_w,
    output logic [31:0] m0_dat_r,
    output logic        m0_ack,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_dat_w,
    output logic [31:0] m1_dat_r,
    output logic        m1_ack,
    output logic        s_stb,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_dat_w,
    input  logic [31:0] s_dat_r,
    output logic [1:0]  o_grant,
    output logic        o_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        last_grant_reg;
    logic [1:0]  win;
    logic        capture;
    logic [31:0] port_dat_r [2];
    logic [1:0]  port_ack;

    // Tie goes to whoever was not served last; last_grant_reg = 1 means m1.
    always_comb begin
        win = 2'b00;
        case ({m1_stb, m0_stb})
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last_grant_reg ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

    assign capture = (state_reg == WAIT) && (cnt_reg == 4'd0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            last_grant_reg <= 1'b1;
            s_stb          <= 1'b0;
            s_we           <= 1'b0;
            s_addr         <= 32'd0;
            s_dat_w        <= 32'd0;
            o_grant        <= 2'b00;
            o_busy         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win != 2'b00) begin
                        o_grant   <= win;
                        o_busy    <= 1'b1;
                        s_stb     <= 1'b1;
                        s_we      <= win[1] ? m1_we    : m0_we;
                        s_addr    <= win[1] ? m1_addr  : m0_addr;
                        s_dat_w   <= win[1] ? m1_dat_w : m0_dat_w;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    s_stb     <= 1'b0;
                    cnt_reg   <= CNT_LOAD;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= ACK;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ACK: begin
                    last_grant_reg <= o_grant[1];
                    o_grant        <= 2'b00;
                    o_busy         <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-requester read-data and ack registers; only the granted port captures.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_port
            logic [31:0] dat_r_reg;
            logic        ack_reg;

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    dat_r_reg <= 32'd0;
                    ack_reg   <= 1'b0;
                end else begin
                    ack_reg <= capture && o_grant[gi];
                    if (capture && o_grant[gi]) begin
                        dat_r_reg <= s_dat_r;
                    end
                end
            end

            assign port_dat_r[gi] = dat_r_reg;
            assign port_ack[gi]   = ack_reg;
        end
    endgenerate

    assign m0_dat_r = port_dat_r[0];
    assign m1_dat_r = port_dat_r[1];
    assign m0_ack   = port_ack[0];
    assign m1_ack   = port_ack[1];

endmodule

// File: doc/wb_uart_arbiter.md
# wb_uart_arbiter

Two-port Wishbone arbiter that shares one `wb_uart` register interface between two independent requesters, e.g. an echo/loopback engine and a host command processor. It serialises accesses with round-robin priority, drives a single-cycle strobe into the UART, waits the UART's fixed register-read latency, and returns data plus a one-cycle acknowledge to the winning requester. It sits directly in front of the `wb_uart` instance and replaces any direct strobe/address wiring to it.

## Interface
- `READ_LATENCY`, default 1: cycles from the edge that samples `s_stb` high until `s_dat_r` is valid. Legal range 1..15.
- `i_clk`  in  1  system clock; all logic on the rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `m0_stb`, `m1_stb`  in  1  request strobe, one per requester; held high until ack.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  32  register address.
- `m0_dat_w`, `m1_dat_w`  in  32  write data.
- `m0_dat_r`, `m1_dat_r`  out  32  read data; valid while the matching ack is high, then held.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `s_stb`  out  1  strobe to `wb_uart`.
- `s_we`  out  1  write enable to `wb_uart`.
- `s_addr`  out  32  address to `wb_uart`.
- `s_dat_w`  out  32  write data to `wb_uart`.
- `s_dat_r`  in  32  read data from `wb_uart`.
- `o_grant`  out  2  one-hot owner of the current transaction; 0 when idle.
- `o_busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE: if exactly one `mX_stb` is high, grant it. If both are high, grant the requester that was not granted last (`last_grant` register, reset value 1, so m0 wins the first tie). Latch the winner's `we`, `addr`, and `dat_w` into `s_we`, `s_addr`, and `s_dat_w`. Set `o_grant`, then go to ISSUE.
- ISSUE: `s_stb` = 1 for exactly this one cycle. Load the wait counter with READ_LATENCY-1, then go to WAIT.
- WAIT: decrement the counter. When it is 0, capture `s_dat_r` into the granted requester's `dat_r` register only, assert that requester's ack, and go to ACK.
- ACK: the ack is high for this one cycle. Update `last_grant`, clear `o_grant`, and return to IDLE.
- Reads and writes use the identical path and latency. Write transactions also capture `s_dat_r`; requesters ignore it.
- Requester rule: a requester deasserts `stb` on the edge at which it samples its ack high. A `stb` still high in IDLE is treated as a new request.
- A requester dropping `stb` after being granted does not abort the transaction; it completes and acks anyway.
- The losing requester's `stb` stays pending, untouched. It is granted in the IDLE cycle immediately after ACK, so neither requester waits more than one transaction.
- `s_we`, `s_addr`, and `s_dat_w` hold their last latched values outside ISSUE. Only `s_stb` qualifies them.
- Reset (asynchronous, any state, including mid-transaction): state = IDLE, `s_stb` = 0, `s_we` = 0, `s_addr` = 0, `s_dat_w` = 0, both acks = 0, both `dat_r` = 0, `o_grant` = 0, `o_busy` = 0, `last_grant` = 1, counter = 0. An interrupted transaction is dropped and never acked.

## Timing
- Edge E0 samples `stb` in IDLE. Then `s_stb` is high for E0→E1, data is captured at E(READ_LATENCY+1), and ack is high for E(READ_LATENCY+1)→E(READ_LATENCY+2).
- With READ_LATENCY=1: ack is high 2 cycles after the request is sampled, and a transaction occupies 4 cycles including IDLE.
- Maximum throughput is one transaction per READ_LATENCY+3 cycles.
- All outputs are registered; there is no combinational path from `mX_*` to `s_*` or from `s_dat_r` to `mX_*`.

## Test plan
- m0 reads addr 0x11, READ_LATENCY=1, UART model returns 0xA5 one cycle after strobe. Required: `s_stb` high for 1 cycle with `s_addr`=0x11 and `s_we`=0; `m0_ack` high exactly 2 cycles after E0 with `m0_dat_r`=0xA5; `m1_ack` stays 0.
- m1 writes 0x42 to addr 0x12. Required: one `s_stb` pulse with `s_we`=1, `s_addr`=0x12, `s_dat_w`=0x42; `m1_ack` is one pulse; `m0_dat_r` is unchanged.
- m0 and m1 assert in the same cycle after reset. Required: m0 is served first and m1 is granted the IDLE cycle after `m0_ack`; repeating the simultaneous request then serves m1 before m0.
- Both requesters hold `stb` continuously for 8 transactions. Required: `o_grant` strictly alternates 01,10,01,...; each transaction spans 4 cycles; every ack has a matching `s_stb`.
- READ_LATENCY=3, model returns 0x3C three cycles after strobe. Required: `m0_ack` at E4 with `m0_dat_r`=0x3C; a stale value on `s_dat_r` at E2 is not captured.
- Assert `i_reset` during WAIT. Required: all outputs read 0 immediately (asynchronously); no ack follows; the next request after release is serviced normally with m0 winning a tie.
